seven_segment_scan_driver: RTL and testbench
============================================

Name: seven_segment_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Latches a packed BCD/hex word on a load strobe and scans one digit per refresh slot.
- Decodes each nibble to segments and drives the digit-enable (anode) lines.
- Sits between the datapath (counters, ALU results) and the board display pins.
- Replaces per-digit combinational decoders with one shared decoder and N anode lines.

Parameters:
- N_DIGITS, 4, number of digits scanned; range 1..8.
- CLK_HZ, 50000000, input clock frequency in Hz.
- SLOT_HZ, 1000, digit slot rate in Hz. DIV = max(1, CLK_HZ/SLOT_HZ) clocks per slot.
- HEX_MODE, 0, 1 = codes 10..15 render A,b,C,d,E,F; 0 = codes 10..15 render segment d only (error bar, active-high pattern 0001000).
- GAP_CYCLES, 2, dead-time length in clocks; used only with the optional feature; must be < DIV.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- load, in, 1, strobe; captures data_in into the shadow register on the rising edge of clk.
- data_in, in, 4*N_DIGITS, packed nibbles; [3:0] = digit 0 (rightmost).
- blank_mask, in, N_DIGITS, bit i = 1 forces digit i dark; sampled live.
- lz_suppress, in, 1, 1 = blank leading zero digits; sampled live.
- seg_out, out, 7, active-low segments; bit0 = a … bit6 = g.
- an_out, out, N_DIGITS, active-low digit enables; bit i = digit i.
- frame_done, out, 1, one-cycle pulse when the scan wraps from digit N_DIGITS-1 to digit 0.

Behaviour:
- Reset (async assert, sync release):
  - slot counter = 0, digit index = 0, shadow = 0.
  - seg_out = 7'h7F, an_out = all ones, frame_done = 0.
- Slot counter:
  - Counts 0..DIV-1. "tick" is the cycle in which the counter equals DIV-1; the counter then wraps to 0.
  - If DIV = 1, tick is asserted every cycle.
- Digit index:
  - Advances on tick: idx -> idx+1, wrapping N_DIGITS-1 -> 0.
  - N_DIGITS = 1: idx stays 0.
- Outputs:
  - seg_out and an_out are registered and update only on tick. They then show the digit selected by the next index (the value idx takes after the tick).
  - First lit digit after reset: digit 1 (digit 0 if N_DIGITS = 1) at the end of the first slot. No digit is lit during slot 0.
- Shadow register:
  - load = 1 captures data_in at that edge.
  - The new value appears at the next tick, never mid-slot.
  - load held high captures every cycle.
  - load coincident with tick: the tick decodes the old shadow; the new value shows from the following tick.
- Decode, active-high patterns before inversion:
  - 0:0111111, 1:0000110, 2:1011011, 3:1001111, 4:1100110
  - 5:1101101, 6:1111101, 7:0000111, 8:1111111, 9:1101111
  - With HEX_MODE = 1: A:1110111, b:1111100, C:0111001, d:1011110, E:1111001, F:1110001.
- Blanking: a dark digit has its an_out bit = 1 and seg_out = 7'h7F. Digit i is dark if either:
  - blank_mask[i] = 1, or
  - lz_suppress = 1, i > 0, and all shadow nibbles at indices >= i are zero.
  - Digit 0 is never dark due to lz_suppress.
- an_out: at most one bit low at any time; one-hot-low selection.
- frame_done: asserted in the cycle after the tick that wraps idx N_DIGITS-1 -> 0. With N_DIGITS = 1 it pulses after every tick.
- Async reset mid-scan: all outputs return to reset values immediately. Scanning restarts from idx 0 with the counter at 0.

Optional Feature:
- Macro: SEVEN_SEGMENT_SCAN_DEADTIME_EN.
- Defined:
  - After each tick, an_out is forced all ones and seg_out = 7'h7F for GAP_CYCLES clocks (anti-ghosting).
  - The new digit is then enabled for the remaining DIV-GAP_CYCLES clocks of the slot.
  - frame_done timing is unchanged.
- Undefined: no dead-time. The new digit is enabled in the cycle immediately after the tick.

Test Plan (CLK_HZ=8, SLOT_HZ=2 → DIV=4, N_DIGITS=4, HEX_MODE=0):
- Reset, then hold rst_n=1 for 20 clocks with no load → an_out cycles 1101,1011,0111,1110 every 4 clocks; seg_out=1000000 (digit "0") each slot; frame_done pulses once per 16 clocks.
- load data_in=16'h1234 one clock → within one slot: an_out=1110 shows seg_out=0011001 ("4"); an_out=0111 shows 1111001 ("1").
- data_in=16'h00A5, lz_suppress=1, load → digit0 = 0010010 ("5"); digit1 = 1110111 (error bar, HEX_MODE=0); digits 2,3 dark with an_out=1111; rerun with HEX_MODE=1 → digit1 = 0001000 ("A").
- blank_mask=4'b0100, data 16'h8888 → digit2 slot shows an_out=1111, seg_out=1111111; other slots seg_out=0000000.
- Assert rst_n=0 mid-slot at digit 2 → same cycle seg_out=1111111, an_out=1111, frame_done=0; after release the first slot completes at counter 3, first lit digit is 1.
- With SEVEN_SEGMENT_SCAN_DEADTIME_EN defined, GAP_CYCLES=2 → per slot: 2 clocks an_out=1111, then 2 clocks of the selected digit.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_segment_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A packed hex/BCD word is captured into a shadow register on a load strobe.
// One shared decoder then feeds the segment lines while the anode lines are
// scanned one digit per refresh slot.
//
// Ports:
//   clk         in   1           system clock
//   rst_n       in   1           asynchronous active-low reset
//   load        in   1           capture data_in into the shadow register
//   data_in     in   4*N_DIGITS  packed nibbles, [3:0] = digit 0 (rightmost)
//   blank_mask  in   N_DIGITS    bit i = 1 forces digit i dark (live)
//   lz_suppress in   1           1 = blank leading zero digits (live)
//   seg_out     out  7           active-low segments, bit0 = a .. bit6 = g
//   an_out      out  N_DIGITS    active-low digit enables, one-hot-low
//   frame_done  out  1           one-cycle pulse after the scan wraps to digit 0
//
// Optional feature macro: SEVEN_SEGMENT_SCAN_DEADTIME_EN
//   When defined, every slot begins with GAP_CYCLES clocks of fully dark
//   output (anti-ghosting) before the selected digit is enabled.
// -----------------------------------------------------------------------------
module seven_segment_scan_driver #(
   parameter int N_DIGITS   = 4,
   parameter int CLK_HZ     = 50000000,
   parameter int SLOT_HZ    = 1000,
   parameter int HEX_MODE   = 0,
   parameter int GAP_CYCLES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*N_DIGITS-1:0]   data_in,
   input  logic [N_DIGITS-1:0]     blank_mask,
   input  logic                    lz_suppress,
   output logic [6:0]              seg_out,
   output logic [N_DIGITS-1:0]     an_out,
   output logic                    frame_done
);

   localparam int DIV_RAW = CLK_HZ / SLOT_HZ;
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
   localparam logic [6:0]       SEG_DARK = 7'h7F;

   // Active-high segment pattern (bit6 = g .. bit0 = a) for one nibble.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] p;
      case (v)
         4'h0: p = 7'b0111111;
         4'h1: p = 7'b0000110;
         4'h2: p = 7'b1011011;
         4'h3: p = 7'b1001111;
         4'h4: p = 7'b1100110;
         4'h5: p = 7'b1101101;
         4'h6: p = 7'b1111101;
         4'h7: p = 7'b0000111;
         4'h8: p = 7'b1111111;
         4'h9: p = 7'b1101111;
         4'hA: p = (HEX_MODE != 0) ? 7'b1110111 : 7'b0001000;
         4'hB: p = (HEX_MODE != 0) ? 7'b1111100 : 7'b0001000;
         4'hC: p = (HEX_MODE != 0) ? 7'b0111001 : 7'b0001000;
         4'hD: p = (HEX_MODE != 0) ? 7'b1011110 : 7'b0001000;
         4'hE: p = (HEX_MODE != 0) ? 7'b1111001 : 7'b0001000;
         default: p = (HEX_MODE != 0) ? 7'b1110001 : 7'b0001000;
      endcase
      return p;
   endfunction

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*N_DIGITS-1:0]   shadow_q, shadow_d;
   logic [6:0]              seg_q, seg_d;
   logic [N_DIGITS-1:0]     an_q, an_d;
   logic                    frame_q, frame_d;
   logic                    tick;

   logic [N_DIGITS-1:0]     zero_above;  // bit i: all nibbles at indices >= i are zero
   logic [N_DIGITS-1:0]     dark_vec;
   logic [N_DIGITS-1:0]     sel_onehot;
   logic [3:0]              nib;
   logic                    dark_sel;
   logic [6:0]              dig_seg;
   logic [N_DIGITS-1:0]     dig_an;

   assign tick = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
      idx_d    = idx_q;
      if (tick) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end
      shadow_d = load ? data_in : shadow_q;
      frame_d  = tick && (idx_q == IDX_LAST);
   end

   // Digit selected for the coming slot, built from the shadow value held
   // before this edge; a load coincident with the tick shows one slot later.
   always_comb begin
      logic acc;
      acc        = 1'b1;
      zero_above = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         acc           = acc && (shadow_q[4*i +: 4] == 4'h0);
         zero_above[i] = acc;
      end

      dark_vec = blank_mask;
      for (int i = 1; i < N_DIGITS; i++) begin
         if (lz_suppress && zero_above[i]) begin
            dark_vec[i] = 1'b1;
         end
      end

      nib        = 4'h0;
      dark_sel   = 1'b0;
      sel_onehot = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_d == IDX_W'(i)) begin
            nib           = shadow_q[4*i +: 4];
            dark_sel      = dark_vec[i];
            sel_onehot[i] = 1'b1;
         end
      end

      dig_seg = dark_sel ? SEG_DARK : ~decode(nib);
      dig_an  = dark_sel ? '1 : ~sel_onehot;
   end

`ifdef SEVEN_SEGMENT_SCAN_DEADTIME_EN
   // The digit picked at the tick is parked here through the dark gap and
   // driven onto the pins once the gap has elapsed.
   logic [6:0]          hold_seg_q, hold_seg_d;
   logic [N_DIGITS-1:0] hold_an_q, hold_an_d;

   always_comb begin
      hold_seg_d = hold_seg_q;
      hold_an_d  = hold_an_q;
      seg_d      = seg_q;
      an_d       = an_q;
      if (tick) begin
         hold_seg_d = dig_seg;
         hold_an_d  = dig_an;
         if (GAP_CYCLES > 0) begin
            seg_d = SEG_DARK;
            an_d  = '1;
         end else begin
            seg_d = dig_seg;
            an_d  = dig_an;
         end
      end else if ((GAP_CYCLES > 0) && (cnt_q == CNT_W'(GAP_CYCLES - 1))) begin
         seg_d = hold_seg_q;
         an_d  = hold_an_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_seg_q <= SEG_DARK;
         hold_an_q  <= '1;
      end else begin
         hold_seg_q <= hold_seg_d;
         hold_an_q  <= hold_an_d;
      end
   end
`else
   always_comb begin
      seg_d = tick ? dig_seg : seg_q;
      an_d  = tick ? dig_an  : an_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         seg_q    <= SEG_DARK;
         an_q     <= '1;
         frame_q  <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         seg_q    <= seg_d;
         an_q     <= an_d;
         frame_q  <= frame_d;
      end
   end

   assign seg_out    = seg_q;
   assign an_out     = an_q;
   assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;

   localparam logic [6:0] S_DARK  = 7'b1111111;
   localparam logic [6:0] S_ZERO  = 7'b1000000;
   localparam logic [6:0] S_ONE   = 7'b1111001;
   localparam logic [6:0] S_TWO   = 7'b0100100;
   localparam logic [6:0] S_THREE = 7'b0110000;
   localparam logic [6:0] S_FOUR  = 7'b0011001;
   localparam logic [6:0] S_FIVE  = 7'b0010010;
   localparam logic [6:0] S_EIGHT = 7'b0000000;
   localparam logic [6:0] S_ERR   = 7'b1110111;
   localparam logic [6:0] S_A     = 7'b0001000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [15:0] data_in = '0;
   logic [3:0]  blank_mask = '0;
   logic        lz_suppress = 1'b0;
   logic [6:0]  seg_out, seg_hex;
   logic [3:0]  an_out, an_hex;
   logic        frame_done, frame_hex;

   int checks = 0;
   int failures = 0;
   int edges;

   seven_segment_scan_driver #(
      .N_DIGITS(4), .CLK_HZ(8), .SLOT_HZ(2), .HEX_MODE(0), .GAP_CYCLES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
      .blank_mask(blank_mask), .lz_suppress(lz_suppress),
      .seg_out(seg_out), .an_out(an_out), .frame_done(frame_done)
   );

   seven_segment_scan_driver #(
      .N_DIGITS(4), .CLK_HZ(8), .SLOT_HZ(2), .HEX_MODE(1), .GAP_CYCLES(2)
   ) dut_hex (
      .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in),
      .blank_mask(blank_mask), .lz_suppress(lz_suppress),
      .seg_out(seg_hex), .an_out(an_hex), .frame_done(frame_hex)
   );

   always #5 clk = ~clk;

   // Rising edges seen since reset release; slot m's digit is stable after edge 4m+3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic wait_edge(input int n);
      while (edges < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load = 1'b0;
      data_in = '0;
      blank_mask = '0;
      lz_suppress = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (seg_out !== S_DARK) begin failures++; $display("FAIL reset_seg: got %b want %b", seg_out, S_DARK); end
      checks++;
      if (an_out !== 4'b1111) begin failures++; $display("FAIL reset_an: got %b want 1111", an_out); end
      checks++;
      if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame: got %b want 0", frame_done); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_edge(3);
      checks++;
      if (an_out !== 4'b1111) begin failures++; $display("FAIL slot0_dark: got %b want 1111", an_out); end
   endtask

   task automatic test_scan();
      logic [3:0] exp_an [1:4];
      exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111; exp_an[4] = 4'b1110;
      apply_reset();
      for (int m = 1; m <= 4; m++) begin
         wait_edge(4*m + 3);
         checks++;
         if (an_out !== exp_an[m]) begin failures++; $display("FAIL scan_an slot%0d: got %b want %b", m, an_out, exp_an[m]); end
         checks++;
         if (seg_out !== S_ZERO) begin failures++; $display("FAIL scan_seg slot%0d: got %b want %b", m, seg_out, S_ZERO); end
      end
   endtask

   task automatic test_frame();
      int pulses = 0;
      int multi = 0;
      apply_reset();
      for (int e = 1; e <= 32; e++) begin
         wait_edge(e);
         if (frame_done === 1'b1) pulses++;
         if ($countones(~an_out) > 1) multi++;
         if (e == 15 || e == 17) begin
            checks++;
            if (frame_done !== 1'b0) begin failures++; $display("FAIL frame_low edge%0d: got %b want 0", e, frame_done); end
         end
         if (e == 16 || e == 32) begin
            checks++;
            if (frame_done !== 1'b1) begin failures++; $display("FAIL frame_pulse edge%0d: got %b want 1", e, frame_done); end
         end
      end
      checks++;
      if (pulses != 2) begin failures++; $display("FAIL frame_count: got %0d want 2", pulses); end
      checks++;
      if (multi != 0) begin failures++; $display("FAIL an_onehot: got %0d multi-low cycles want 0", multi); end
   endtask

   task automatic test_load_1234();
      logic [3:0] exp_an [1:4];
      logic [6:0] exp_seg [1:4];
      exp_an[1] = 4'b1101; exp_seg[1] = S_THREE;
      exp_an[2] = 4'b1011; exp_seg[2] = S_TWO;
      exp_an[3] = 4'b0111; exp_seg[3] = S_ONE;
      exp_an[4] = 4'b1110; exp_seg[4] = S_FOUR;
      apply_reset();
      data_in = 16'h1234;
      load = 1'b1;
      wait_edge(1);
      load = 1'b0;
      for (int m = 1; m <= 4; m++) begin
         wait_edge(4*m + 3);
         checks++;
         if (an_out !== exp_an[m] || seg_out !== exp_seg[m]) begin
            failures++;
            $display("FAIL load1234 slot%0d: got an=%b seg=%b want an=%b seg=%b", m, an_out, seg_out, exp_an[m], exp_seg[m]);
         end
      end
   endtask

   task automatic test_lz_hex();
      logic [3:0] exp_an [1:4];
      logic [6:0] exp_seg [1:4];
      logic [6:0] exp_hex [1:4];
      exp_an[1] = 4'b1101; exp_seg[1] = S_ERR;  exp_hex[1] = S_A;
      exp_an[2] = 4'b1111; exp_seg[2] = S_DARK; exp_hex[2] = S_DARK;
      exp_an[3] = 4'b1111; exp_seg[3] = S_DARK; exp_hex[3] = S_DARK;
      exp_an[4] = 4'b1110; exp_seg[4] = S_FIVE; exp_hex[4] = S_FIVE;
      apply_reset();
      data_in = 16'h00A5;
      lz_suppress = 1'b1;
      load = 1'b1;
      wait_edge(1);
      load = 1'b0;
      for (int m = 1; m <= 4; m++) begin
         wait_edge(4*m + 3);
         checks++;
         if (an_out !== exp_an[m] || seg_out !== exp_seg[m]) begin
            failures++;
            $display("FAIL lz_dec slot%0d: got an=%b seg=%b want an=%b seg=%b", m, an_out, seg_out, exp_an[m], exp_seg[m]);
         end
         checks++;
         if (an_hex !== exp_an[m] || seg_hex !== exp_hex[m]) begin
            failures++;
            $display("FAIL lz_hex slot%0d: got an=%b seg=%b want an=%b seg=%b", m, an_hex, seg_hex, exp_an[m], exp_hex[m]);
         end
      end
      lz_suppress = 1'b0;
   endtask

   task automatic test_blank_mask();
      logic [3:0] exp_an [1:4];
      logic [6:0] exp_seg [1:4];
      exp_an[1] = 4'b1101; exp_seg[1] = S_EIGHT;
      exp_an[2] = 4'b1111; exp_seg[2] = S_DARK;
      exp_an[3] = 4'b0111; exp_seg[3] = S_EIGHT;
      exp_an[4] = 4'b1110; exp_seg[4] = S_EIGHT;
      apply_reset();
      data_in = 16'h8888;
      blank_mask = 4'b0100;
      load = 1'b1;
      wait_edge(1);
      load = 1'b0;
      for (int m = 1; m <= 4; m++) begin
         wait_edge(4*m + 3);
         checks++;
         if (an_out !== exp_an[m] || seg_out !== exp_seg[m]) begin
            failures++;
            $display("FAIL blank slot%0d: got an=%b seg=%b want an=%b seg=%b", m, an_out, seg_out, exp_an[m], exp_seg[m]);
         end
      end
      blank_mask = '0;
   endtask

   task automatic test_load_held();
      apply_reset();
      load = 1'b1;
      data_in = 16'h1111;
      wait_edge(1);
      data_in = 16'h5555;
      wait_edge(2);
      data_in = 16'h8888;
      wait_edge(3);
      data_in = 16'h2222;  // captured on the tick edge: one slot late
      wait_edge(4);
      load = 1'b0;
      wait_edge(7);
      checks++;
      if (seg_out !== S_EIGHT || an_out !== 4'b1101) begin
         failures++;
         $display("FAIL load_held slot1: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, S_EIGHT);
      end
      wait_edge(11);
      checks++;
      if (seg_out !== S_TWO || an_out !== 4'b1011) begin
         failures++;
         $display("FAIL load_on_tick slot2: got an=%b seg=%b want an=1011 seg=%b", an_out, seg_out, S_TWO);
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      data_in = 16'h1111;
      load = 1'b1;
      wait_edge(1);
      load = 1'b0;
      wait_edge(3);
      data_in = 16'h2222;
      load = 1'b1;
      wait_edge(4);
      load = 1'b0;
      wait_edge(7);
      checks++;
      if (seg_out !== S_ONE) begin failures++; $display("FAIL b2b_old: got %b want %b", seg_out, S_ONE); end
      wait_edge(11);
      checks++;
      if (seg_out !== S_TWO) begin failures++; $display("FAIL b2b_new: got %b want %b", seg_out, S_TWO); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      wait_edge(10);
      checks++;
      if (an_out !== 4'b1011) begin failures++; $display("FAIL pre_reset_an: got %b want 1011", an_out); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (seg_out !== S_DARK || an_out !== 4'b1111 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL async_reset: got seg=%b an=%b fd=%b want seg=1111111 an=1111 fd=0", seg_out, an_out, frame_done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_edge(3);
      checks++;
      if (an_out !== 4'b1111) begin failures++; $display("FAIL restart_slot0: got %b want 1111", an_out); end
      wait_edge(7);
      checks++;
      if (an_out !== 4'b1101) begin failures++; $display("FAIL restart_first: got %b want 1101", an_out); end
   endtask

   task automatic test_gap();
      apply_reset();
`ifdef SEVEN_SEGMENT_SCAN_DEADTIME_EN
      wait_edge(4);
      checks++;
      if (an_out !== 4'b1111 || seg_out !== S_DARK) begin failures++; $display("FAIL gap_c0: got an=%b seg=%b want an=1111 seg=1111111", an_out, seg_out); end
      wait_edge(5);
      checks++;
      if (an_out !== 4'b1111 || seg_out !== S_DARK) begin failures++; $display("FAIL gap_c1: got an=%b seg=%b want an=1111 seg=1111111", an_out, seg_out); end
      wait_edge(6);
      checks++;
      if (an_out !== 4'b1101 || seg_out !== S_ZERO) begin failures++; $display("FAIL gap_lit: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, S_ZERO); end
`else
      wait_edge(4);
      checks++;
      if (an_out !== 4'b1101 || seg_out !== S_ZERO) begin failures++; $display("FAIL no_gap: got an=%b seg=%b want an=1101 seg=%b", an_out, seg_out, S_ZERO); end
`endif
   endtask

   initial begin
      test_reset();
      test_scan();
      test_frame();
      test_load_1234();
      test_lz_hex();
      test_blank_mask();
      test_load_held();
      test_back_to_back();
      test_async_reset();
      test_gap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
